// File: rtl/nf10_axis_unpacker_if.sv
// AXI4-Stream bundle (tdata/tstrb/tuser/tvalid/tready/tlast) shared by the
// narrow input and wide output sides of nf10_axis_unpacker.
interface nf10_axis_unpacker_if #(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned TuserWidth = 128
);
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tstrb;
    logic [TuserWidth-1:0]  tuser;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_unpacker.sv
// Packs narrow AXI4-Stream beats into a wide stream, holds first-beat tuser for the
// packet and checks LEN against the received byte count. NF10_AXIS_UNPACKER_STATS_EN enables counters.
module nf10_axis_unpacker #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH = 64,
    parameter int unsigned C_M_AXIS_DATA_WIDTH = 256,
    parameter int unsigned C_TUSER_DATA_WIDTH  = 128,
    parameter int unsigned C_LEN_DATA_WIDTH    = 16,
    parameter int unsigned C_COUNT_WIDTH       = 32
) (
    input  logic                     axi_aclk,
    input  logic                     axi_resetn,
    nf10_axis_unpacker_if.slave      s_axis,
    nf10_axis_unpacker_if.master     m_axis,
    output logic                     len_err,
    output logic [C_COUNT_WIDTH-1:0] pkt_count,
    output logic [C_COUNT_WIDTH-1:0] err_count
);
    localparam int unsigned SBytes = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned MBytes = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned Ratio  = C_M_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH;
    localparam int unsigned LaneW  = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int unsigned CntW   = $clog2(SBytes) + 1;
    localparam int unsigned SumW   = C_LEN_DATA_WIDTH + 1;

    typedef enum logic [0:0] {StFirst, StBody} state_e;

    state_e                          state_q, state_d;
    logic [LaneW-1:0]                lane_q, lane_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  acc_data_q, acc_data_d, word_data;
    logic [MBytes-1:0]               acc_strb_q, acc_strb_d, word_strb;
    logic [C_TUSER_DATA_WIDTH-1:0]   meta_q, meta_d, cur_meta;
    logic [C_LEN_DATA_WIDTH-1:0]     sum_q, sum_d, sum_sat;
    logic [SumW-1:0]                 sum_wide;
    logic [CntW-1:0]                 beat_bytes;

    logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [MBytes-1:0]               tstrb_q, tstrb_d;
    logic [C_TUSER_DATA_WIDTH-1:0]   tuser_q, tuser_d;
    logic                            tvalid_q, tvalid_d;
    logic                            tlast_q, tlast_d;
    logic                            len_err_q, len_err_d;

    logic s_ready, accept, last_lane, complete, pkt_end, mismatch;

    assign s_ready   = ~tvalid_q | m_axis.tready;
    assign accept    = s_axis.tvalid & s_ready;
    assign last_lane = (lane_q == LaneW'(Ratio - 1));
    assign complete  = accept & (last_lane | s_axis.tlast);
    assign pkt_end   = accept & s_axis.tlast;
    assign cur_meta  = (state_q == StFirst) ? s_axis.tuser : meta_q;

    // Current beat merged into the accumulator; untouched upper lanes stay zero.
    always_comb begin
        word_data = acc_data_q;
        word_strb = acc_strb_q;
        for (int unsigned l = 0; l < Ratio; l++) begin
            if (lane_q == LaneW'(l)) begin
                word_data[l*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH] = s_axis.tdata;
                word_strb[l*SBytes +: SBytes] = s_axis.tstrb;
            end
        end
    end

    always_comb begin
        beat_bytes = '0;
        for (int unsigned i = 0; i < SBytes; i++) begin
            if (s_axis.tstrb[i]) beat_bytes = CntW'(i + 1);
        end
        sum_wide = SumW'(sum_q) + SumW'(beat_bytes);
        sum_sat  = sum_wide[C_LEN_DATA_WIDTH] ? '1 : sum_wide[C_LEN_DATA_WIDTH-1:0];
    end

    assign mismatch = pkt_end & (sum_sat != cur_meta[C_LEN_DATA_WIDTH-1:0]);

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_data_d = acc_data_q;
        acc_strb_d = acc_strb_q;
        meta_d     = meta_q;
        sum_d      = sum_q;
        if (accept) begin
            unique case (state_q)
                StFirst: begin
                    meta_d = s_axis.tuser;
                    if (!s_axis.tlast) state_d = StBody;
                end
                StBody: begin
                    if (s_axis.tlast) state_d = StFirst;
                end
                default: state_d = StFirst;
            endcase
            sum_d = s_axis.tlast ? '0 : sum_sat;
            if (complete) begin
                lane_d     = '0;
                acc_data_d = '0;
                acc_strb_d = '0;
            end else begin
                lane_d     = lane_q + LaneW'(1);
                acc_data_d = word_data;
                acc_strb_d = word_strb;
            end
        end
    end

    always_comb begin
        tdata_d   = tdata_q;
        tstrb_d   = tstrb_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q & ~m_axis.tready;
        len_err_d = mismatch;
        if (complete) begin
            tdata_d  = word_data;
            tstrb_d  = word_strb;
            tuser_d  = cur_meta;
            tlast_d  = s_axis.tlast;
            tvalid_d = 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q    <= StFirst;
            lane_q     <= '0;
            acc_data_q <= '0;
            acc_strb_q <= '0;
            meta_q     <= '0;
            sum_q      <= '0;
            tdata_q    <= '0;
            tstrb_q    <= '0;
            tuser_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            acc_data_q <= acc_data_d;
            acc_strb_q <= acc_strb_d;
            meta_q     <= meta_d;
            sum_q      <= sum_d;
            tdata_q    <= tdata_d;
            tstrb_q    <= tstrb_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            len_err_q  <= len_err_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tstrb  = tstrb_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign len_err       = len_err_q;

`ifdef NF10_AXIS_UNPACKER_STATS_EN
    logic [C_COUNT_WIDTH-1:0] pkt_count_q, err_count_q;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (pkt_end) pkt_count_q <= pkt_count_q + C_COUNT_WIDTH'(1);
            if (mismatch) err_count_q <= err_count_q + C_COUNT_WIDTH'(1);
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_nf10_axis_unpacker.sv
// Randomized scoreboard bench for nf10_axis_unpacker: packets are modelled as byte
// streams sliced into wide words; a monitor compares every presented output word.
module tb_nf10_axis_unpacker;
    localparam int unsigned SW    = 64;
    localparam int unsigned MW    = 256;
    localparam int unsigned TUW   = 128;
    localparam int unsigned CW    = 32;
    localparam int unsigned RATIO = MW / SW;
    localparam int unsigned SB    = SW / 8;
    localparam int unsigned MB    = MW / 8;
`ifdef NF10_AXIS_UNPACKER_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nf10_axis_unpacker_if #(.DataWidth(SW), .TuserWidth(TUW)) s_axis_if ();
    nf10_axis_unpacker_if #(.DataWidth(MW), .TuserWidth(TUW)) m_axis_if ();
    logic          len_err;
    logic [CW-1:0] pkt_count, err_count;

    nf10_axis_unpacker dut (
        .axi_aclk   (clk),
        .axi_resetn (rst_n),
        .s_axis     (s_axis_if),
        .m_axis     (m_axis_if),
        .len_err    (len_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    typedef struct {
        logic [MW-1:0]  data;
        logic [MB-1:0]  strb;
        logic [TUW-1:0] user;
        logic           last;
    } word_t;
    typedef struct {
        int unsigned cyc;
        logic        flag;
    } err_t;

    word_t       exp_q[$];
    err_t        err_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int          exp_pkts = 0;
    int          exp_errs = 0;
    int          bp_mode = 2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output-side backpressure: 0 random, 1 stalled, 2 always ready.
    initial begin
        m_axis_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       m_axis_if.tready = ($urandom_range(0, 3) != 0);
                1:       m_axis_if.tready = 1'b0;
                default: m_axis_if.tready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("s_tready", MW'(s_axis_if.tready), MW'(!m_axis_if.tvalid || m_axis_if.tready));
            if (m_axis_if.tvalid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_word: got unexpected word %h expected none", m_axis_if.tdata);
                end else begin
                    check("out_data", m_axis_if.tdata, exp_q[0].data);
                    check("out_strb", MW'(m_axis_if.tstrb), MW'(exp_q[0].strb));
                    check("out_user", MW'(m_axis_if.tuser), MW'(exp_q[0].user));
                    check("out_last", MW'(m_axis_if.tlast), MW'(exp_q[0].last));
                    if (m_axis_if.tready) void'(exp_q.pop_front());
                end
            end
            if (err_q.size() != 0 && err_q[0].cyc == cyc) begin
                check("len_err", MW'(len_err), MW'(err_q[0].flag));
                void'(err_q.pop_front());
            end else begin
                check("len_err_idle", MW'(len_err), '0);
            end
        end
    end

    task automatic drive_beat(input logic [SW-1:0] d, input logic [SB-1:0] st,
                              input logic [TUW-1:0] u, input logic last,
                              input logic eflag, input bit model);
        int guard = 0;
        bit done = 0;
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = d;
        s_axis_if.tstrb  = st;
        s_axis_if.tuser  = u;
        s_axis_if.tlast  = last;
        while (!done) begin
            @(negedge clk);
            if (s_axis_if.tready) begin
                done = 1;
                if (last && model) begin
                    err_q.push_back('{cyc + 1, eflag});
                    exp_pkts++;
                    if (eflag) exp_errs++;
                end
            end
            @(posedge clk);
            #1;
            if (!done && ++guard > 2000) begin
                $display("FAIL accept_timeout: got no s_tready expected accept within 2000 cycles");
                $fatal(1);
            end
        end
        s_axis_if.tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: bytes split into SB-byte beats, beats grouped RATIO per wide word from packet start.
    task automatic send_pkt(input int nbytes, input int len, input int spt, input int dpt,
                            input bit rand_strb, input int max_beats, input bit model);
        int              beats;
        int              rem;
        logic            eflag;
        logic [TUW-1:0]  user;
        logic [SW-1:0]   d[$];
        logic [SB-1:0]   st[$];
        word_t           w;
        beats = (nbytes + SB - 1) / SB;
        rem   = nbytes - int'(SB) * (beats - 1);
        user  = {$urandom(), $urandom(), $urandom(), $urandom()};
        user[15:0]  = 16'(len);
        user[23:16] = 8'(spt);
        user[31:24] = 8'(dpt);
        eflag = ((nbytes > 65535 ? 65535 : nbytes) != len);
        for (int b = 0; b < beats; b++) begin
            d.push_back({$urandom(), $urandom()});
            if (b != beats - 1)
                st.push_back('1);
            else if (rand_strb)
                st.push_back(SB'($urandom() & ((1 << (rem - 1)) - 1)) | SB'(1 << (rem - 1)));
            else
                st.push_back(SB'((1 << rem) - 1));
        end
        if (model) begin
            for (int wi = 0; wi * int'(RATIO) < beats; wi++) begin
                w.data = '0;
                w.strb = '0;
                for (int k = 0; k < int'(RATIO); k++) begin
                    if (wi * int'(RATIO) + k < beats) begin
                        w.data[k*SW +: SW] = d[wi*RATIO + k];
                        w.strb[k*SB +: SB] = st[wi*RATIO + k];
                    end
                end
                w.user = user;
                w.last = ((wi + 1) * int'(RATIO) >= beats);
                exp_q.push_back(w);
            end
        end
        for (int b = 0; b < beats && b < max_beats; b++) begin
            drive_beat(d[b], st[b], (b == 0) ? user : {$urandom(), $urandom(), $urandom(), $urandom()},
                       (b == beats - 1), eflag, model);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain", MW'(exp_q.size() + err_q.size()), '0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_counts();
        check("pkt_count", MW'(pkt_count), StatsEn ? MW'(exp_pkts) : '0);
        check("err_count", MW'(err_count), StatsEn ? MW'(exp_errs) : '0);
    endtask

    task automatic check_reset_outputs();
        check("rst_tvalid", MW'(m_axis_if.tvalid), '0);
        check("rst_tlast", MW'(m_axis_if.tlast), '0);
        check("rst_tdata", m_axis_if.tdata, '0);
        check("rst_tstrb", MW'(m_axis_if.tstrb), '0);
        check("rst_tuser", MW'(m_axis_if.tuser), '0);
        check("rst_len_err", MW'(len_err), '0);
        check("rst_pkt_count", MW'(pkt_count), '0);
        check("rst_err_count", MW'(err_count), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected finish before 500us");
        $fatal(1);
    end

    initial begin
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tstrb  = '0;
        s_axis_if.tuser  = '0;
        s_axis_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_reset", MW'(s_axis_if.tready), MW'(1));
        @(posedge clk);
        #1;

        // Directed packets: 60B ok, 64B with LEN=65, single beat, 256B.
        send_pkt(60, 60, 1, 4, 1'b0, 1000, 1'b1);
        send_pkt(64, 65, 2, 1, 1'b0, 1000, 1'b1);
        send_pkt(8, 8, 3, 2, 1'b0, 1000, 1'b1);
        send_pkt(256, 256, 0, 8, 1'b0, 1000, 1'b1);
        wait_drain();
        check_counts();

        // Output stalled for 10 cycles in the middle of a packet.
        fork
            send_pkt(200, 200, 5, 6, 1'b0, 1000, 1'b1);
            begin
                repeat (6) @(posedge clk);
                bp_mode = 1;
                repeat (10) @(posedge clk);
                bp_mode = 2;
            end
        join
        wait_drain();

        bp_mode = 0;
        for (int p = 0; p < 40; p++) begin
            int nb;
            int ln;
            nb = $urandom_range(1, 300);
            ln = ($urandom_range(0, 2) != 0) ? nb : $urandom_range(0, 400);
            send_pkt(nb, ln, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1000, 1'b1);
        end
        bp_mode = 2;
        wait_drain();
        check_counts();

        // Reset in the middle of a packet, then a fresh 60-byte packet.
        send_pkt(64, 64, 1, 1, 1'b0, 3, 1'b0);
        rst_n = 1'b0;
        exp_pkts = 0;
        exp_errs = 0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(60, 60, 1, 4, 1'b0, 1000, 1'b1);
        wait_drain();
        check_counts();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
